// File: rtl/gpu_ucode_sequencer.sv
// Microcode fetch/issue stage: owns the ucode PC, resolves control flow locally and
// issues datapath ops as one-cycle pulses, stalling on VMEM-read / framebuffer-write handshakes.
`ifndef GPU_UOP_SZ
`define GPU_UOP_SZ 32
`endif

module gpu_ucode_sequencer #(
    parameter int unsigned PC_W  = 8,
    parameter int unsigned UOP_W = `GPU_UOP_SZ
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iEnable,
    output logic [PC_W-1:0]  oUopAddr,
    input  logic [UOP_W-1:0] iUop,
    input  logic             iZero,
    output logic [UOP_W-1:0] oIssueUop,
    output logic             oIssueValid,
    output logic             oVmemReq,
    input  logic             iVmemAck,
    output logic             oFbReq,
    input  logic             iFbAck,
    output logic [1:0]       oState
);

    localparam logic [4:0] OpGnop      = 5'd0;
    localparam logic [4:0] OpGgoto     = 5'd1;
    localparam logic [4:0] OpGjz       = 5'd2;
    localparam logic [4:0] OpGjnz      = 5'd3;
    localparam logic [4:0] OpGrvmem    = 5'd4;
    localparam logic [4:0] OpGwfbuffer = 5'd5;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StWaitVmem = 2'd2,
        StWaitFb   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [UOP_W-1:0] issue_uop_q, issue_uop_d;
    logic             issue_valid_q, issue_valid_d;
    logic             vmem_req_q, vmem_req_d;
    logic             fb_req_q, fb_req_d;
    logic             issued_last_q, issued_last_d;

    logic [4:0]       opcode;
    logic [PC_W-1:0]  pc_inc;
    logic [PC_W-1:0]  jump_pc;
    logic             taken;

    assign opcode  = iUop[UOP_W-1 -: 5];
    assign pc_inc  = pc_q + PC_W'(1);
    assign jump_pc = iUop[PC_W-1:0];
    assign taken   = (opcode == OpGjz) ? iZero : !iZero;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            issue_uop_q   <= '0;
            issue_valid_q <= 1'b0;
            vmem_req_q    <= 1'b0;
            fb_req_q      <= 1'b0;
            issued_last_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            issue_uop_q   <= issue_uop_d;
            issue_valid_q <= issue_valid_d;
            vmem_req_q    <= vmem_req_d;
            fb_req_q      <= fb_req_d;
            issued_last_q <= issued_last_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        issue_uop_d   = issue_uop_q;
        issue_valid_d = 1'b0;
        vmem_req_d    = vmem_req_q;
        fb_req_d      = fb_req_q;
        issued_last_d = 1'b0;
        case (state_q)
            StIdle: begin
                pc_d = '0;
                if (iEnable) state_d = StRun;
            end
            StRun: begin
                if (!iEnable) begin
                    state_d = StIdle;
                    pc_d    = '0;
                end else begin
                    case (opcode)
                        OpGnop:  pc_d = pc_inc;
                        OpGgoto: pc_d = jump_pc;
                        OpGjz, OpGjnz: begin
                            // A just-issued op has not updated iZero yet; hold one cycle.
                            if (!issued_last_q) pc_d = taken ? jump_pc : pc_inc;
                        end
                        default: begin
                            issue_uop_d   = iUop;
                            issue_valid_d = 1'b1;
                            issued_last_d = 1'b1;
                            pc_d          = pc_inc;
                            if (opcode == OpGrvmem) begin
                                vmem_req_d = 1'b1;
                                state_d    = StWaitVmem;
                            end else if (opcode == OpGwfbuffer) begin
                                fb_req_d = 1'b1;
                                state_d  = StWaitFb;
                            end
                        end
                    endcase
                end
            end
            StWaitVmem: begin
                if (iVmemAck) begin
                    vmem_req_d = 1'b0;
                    state_d    = iEnable ? StRun : StIdle;
                    if (!iEnable) pc_d = '0;
                end
            end
            StWaitFb: begin
                if (iFbAck) begin
                    fb_req_d = 1'b0;
                    state_d  = iEnable ? StRun : StIdle;
                    if (!iEnable) pc_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        oUopAddr    = pc_q;
        oIssueUop   = issue_uop_q;
        oIssueValid = issue_valid_q;
        oVmemReq    = vmem_req_q;
        oFbReq      = fb_req_q;
        oState      = state_q;
    end

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Bench for gpu_ucode_sequencer: directed scenarios then random ROM/handshake traffic,
// every cycle compared against a cycle-level behavioural model of the sequencer.
`timescale 1ns/1ps

module tb_gpu_ucode_sequencer;

    localparam logic [4:0] GNOP  = 5'd0;
    localparam logic [4:0] GGOTO = 5'd1;
    localparam logic [4:0] GJZ   = 5'd2;
    localparam logic [4:0] GJNZ  = 5'd3;
    localparam logic [4:0] GRVM  = 5'd4;
    localparam logic [4:0] GWFB  = 5'd5;
    localparam logic [4:0] GSUBL = 5'd10;

    localparam int MIDLE = 0;
    localparam int MRUN  = 1;
    localparam int MWV   = 2;
    localparam int MWF   = 3;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iEnable = 1'b0;
    logic [7:0]  oUopAddr;
    logic [31:0] iUop;
    logic        iZero = 1'b0;
    logic [31:0] oIssueUop;
    logic        oIssueValid;
    logic        oVmemReq;
    logic        iVmemAck = 1'b0;
    logic        oFbReq;
    logic        iFbAck = 1'b0;
    logic [1:0]  oState;

    logic [31:0] rom [256];

    int checks = 0;
    int errors = 0;

    logic [7:0]  m_pc = '0;
    int          m_mode = MIDLE;
    logic [31:0] m_iu = '0;
    bit          m_iv = 0, m_vr = 0, m_fr = 0, m_il = 0;

    gpu_ucode_sequencer #(.PC_W(8), .UOP_W(32)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iEnable     (iEnable),
        .oUopAddr    (oUopAddr),
        .iUop        (iUop),
        .iZero       (iZero),
        .oIssueUop   (oIssueUop),
        .oIssueValid (oIssueValid),
        .oVmemReq    (oVmemReq),
        .iVmemAck    (iVmemAck),
        .oFbReq      (oFbReq),
        .iFbAck      (iFbAck),
        .oState      (oState)
    );

    assign iUop = rom[oUopAddr];

    always #5 Clock = ~Clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [17:0] tgt);
        return {op, 9'd0, tgt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the model applies the sequencer's rules to the inputs seen at the edge.
    task automatic step();
        logic [31:0] u;
        logic [4:0]  op;
        logic        tk, ack;
        logic [7:0]  n_pc;
        int          n_mode;
        logic [31:0] n_iu;
        bit          n_iv, n_vr, n_fr, n_il;
        u = rom[m_pc];
        op = u[31:27];
        n_pc = m_pc; n_mode = m_mode; n_iu = m_iu;
        n_iv = 0; n_vr = m_vr; n_fr = m_fr; n_il = 0;
        if (!Reset) begin
            n_pc = '0; n_mode = MIDLE; n_iu = '0; n_vr = 0; n_fr = 0;
        end else if (m_mode == MIDLE) begin
            if (iEnable) n_mode = MRUN;
        end else if (m_mode == MRUN) begin
            if (!iEnable) begin
                n_mode = MIDLE; n_pc = '0;
            end else if (op == GNOP) begin
                n_pc = m_pc + 8'd1;
            end else if (op == GGOTO) begin
                n_pc = u[7:0];
            end else if (op == GJZ || op == GJNZ) begin
                if (!m_il) begin
                    tk = (op == GJZ) ? iZero : !iZero;
                    n_pc = tk ? u[7:0] : m_pc + 8'd1;
                end
            end else begin
                n_iu = u; n_iv = 1; n_il = 1; n_pc = m_pc + 8'd1;
                if (op == GRVM) begin n_vr = 1; n_mode = MWV; end
                if (op == GWFB) begin n_fr = 1; n_mode = MWF; end
            end
        end else begin
            ack = (m_mode == MWV) ? iVmemAck : iFbAck;
            if (ack) begin
                n_vr = 0; n_fr = 0;
                n_mode = iEnable ? MRUN : MIDLE;
                if (!iEnable) n_pc = '0;
            end
        end
        @(posedge Clock);
        #1;
        m_pc = n_pc; m_mode = n_mode; m_iu = n_iu;
        m_iv = n_iv; m_vr = n_vr; m_fr = n_fr; m_il = n_il;
        check("pc", 32'(oUopAddr), 32'(m_pc));
        check("state", 32'(oState), 32'(m_mode));
        check("issue_valid", 32'(oIssueValid), 32'(m_iv));
        check("issue_uop", oIssueUop, m_iu);
        check("vmem_req", 32'(oVmemReq), 32'(m_vr));
        check("fb_req", 32'(oFbReq), 32'(m_fr));
    endtask

    task automatic run_to_pc(input logic [7:0] target, input int max);
        int n = 0;
        while (m_pc != target && n < max) begin
            step();
            n++;
        end
        check("reach_pc", 32'(oUopAddr), 32'(target));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = mk(GNOP, 18'd0);
        rom[1]   = mk(GSUBL, 18'h12345);
        rom[4]   = mk(GGOTO, 18'h3FF05);
        rom[5]   = mk(GGOTO, 18'd60);
        rom[6]   = mk(GRVM, 18'h00ABC);
        rom[7]   = mk(GJZ, 18'd15);
        rom[15]  = mk(GWFB, 18'h00DEF);
        rom[60]  = mk(GSUBL, 18'h00001);
        rom[61]  = mk(GJNZ, 18'd5);
        rom[62]  = mk(GGOTO, 18'h000FF);
        rom[255] = mk(6'd20 > 0 ? 5'd20 : 5'd20, 18'h0BEEF);

        // Reset held two cycles: everything at zero.
        step(); step();
        check("rst_addr", 32'(oUopAddr), 32'd0);
        check("rst_valid", 32'(oIssueValid), 32'd0);
        check("rst_state", 32'(oState), 32'd0);
        Reset = 1'b1; iEnable = 1'b1; iZero = 1'b1;
        step();
        check("en_run", 32'(oState), 32'd1);
        step();
        check("nop_pc1", 32'(oUopAddr), 32'd1);
        step();
        check("alu_issue", 32'(oIssueValid), 32'd1);
        check("alu_uop", oIssueUop, mk(GSUBL, 18'h12345));

        // ggoto ignores target bits above PC_W.
        run_to_pc(8'd4, 10);
        step();
        check("goto_pc", 32'(oUopAddr), 32'h05);

        // gsubl then gjnz: bubble, then flag sampled fresh (taken).
        step(); step();
        check("sub_issue", 32'(oIssueValid), 32'd1);
        step();
        check("bubble_pc", 32'(oUopAddr), 32'd61);
        iZero = 1'b0;
        step();
        check("jnz_taken", 32'(oUopAddr), 32'd5);

        // Same again, flag ends up 1: not taken.
        step(); step(); step();
        check("bubble2_pc", 32'(oUopAddr), 32'd61);
        iZero = 1'b1;
        rom[5] = mk(GNOP, 18'd0);
        step();
        check("jnz_fall", 32'(oUopAddr), 32'd62);

        // Goto 255, issue there, wrap to 0.
        step();
        check("goto_255", 32'(oUopAddr), 32'd255);
        step();
        check("wrap_pc", 32'(oUopAddr), 32'd0);
        check("wrap_issue", 32'(oIssueValid), 32'd1);

        // VMEM handshake, ack after three waiting cycles.
        run_to_pc(8'd6, 20);
        step();
        check("vmem_state", 32'(oState), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            check("vmem_hold", 32'(oVmemReq), 32'd1);
            check("vmem_pc", 32'(oUopAddr), 32'd7);
        end
        iVmemAck = 1'b1;
        step();
        iVmemAck = 1'b0;
        check("vmem_done", 32'(oVmemReq), 32'd0);
        check("vmem_run", 32'(oState), 32'd1);
        step();
        check("jz_nobubble", 32'(oUopAddr), 32'd15);

        // FB handshake with disable while waiting.
        step();
        check("fb_req", 32'(oFbReq), 32'd1);
        iEnable = 1'b0;
        step(); step();
        iFbAck = 1'b1;
        step();
        iFbAck = 1'b0;
        check("fb_done", 32'(oFbReq), 32'd0);
        check("fb_idle", 32'(oState), 32'd0);
        check("fb_pc0", 32'(oUopAddr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_noissue", 32'(oIssueValid), 32'd0);
        end

        // Reset in the middle of a VMEM wait; late ack ignored.
        iEnable = 1'b1;
        for (int i = 0; i < 30 && m_mode != MWV; i++) step();
        check("rw_state", 32'(oState), 32'd2);
        step();
        Reset = 1'b0;
        step();
        check("rw_req", 32'(oVmemReq), 32'd0);
        check("rw_idle", 32'(oState), 32'd0);
        Reset = 1'b1; iEnable = 1'b0; iVmemAck = 1'b1;
        step(); step();
        check("late_ack", 32'(oVmemReq), 32'd0);
        iVmemAck = 1'b0;

        // Random programs and handshake timing.
        for (int i = 1; i < 256; i++) begin
            int r;
            logic [17:0] t;
            r = $urandom_range(0, 99);
            t = 18'($urandom);
            if (r < 30)      rom[i] = mk(GNOP, t);
            else if (r < 40) rom[i] = mk(GGOTO, t);
            else if (r < 55) rom[i] = mk(GJZ, t);
            else if (r < 70) rom[i] = mk(GJNZ, t);
            else if (r < 77) rom[i] = mk(GRVM, t);
            else if (r < 84) rom[i] = mk(GWFB, t);
            else             rom[i] = {5'($urandom_range(6, 31)), 27'($urandom)};
        end
        for (int i = 0; i < 1500; i++) begin
            iZero    = 1'($urandom);
            iEnable  = ($urandom_range(0, 19) != 0);
            Reset    = ($urandom_range(0, 199) != 0);
            iVmemAck = ($urandom_range(0, 3) == 0);
            iFbAck   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
